// File: rtl/byte_ram_stream_reader.sv
// Streams a contiguous byte range out of the byte RAM read port.
// A credit check sizes reads so the output FIFO can never overflow.
module byte_ram_stream_reader #(
  parameter int FIFO_DEPTH = 3,
  parameter int ROM_DEPTH  = 300,
  parameter int ADDR_W     = $clog2(ROM_DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   Length,
  input  logic              Abort,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] RamReadAddr,
  output logic              RamReadEnable,
  input  logic [7:0]        RamReadData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [7:0]        OutData,
  output logic              OutLast
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW:0] DEPTH_C =
    (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX =
    PW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX =
    ADDR_W'(ROM_DEPTH - 1);
  localparam logic [ADDR_W:0] REM_ONE =
    (ADDR_W + 1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic [7:0]        fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              issue;
  logic              push;
  logic              pop;

  assign Busy = (state == S_RUN);
  assign Done = (state == S_FIN);

  // Credits count entries held plus the read still in flight,
  // so nothing here depends on OutReady.
  assign used = {1'b0, count}
              + {{CW{1'b0}}, inflight};

  assign issue = Busy
              && (remaining != '0)
              && (used < DEPTH_C)
              && !Abort
              && !Rst;

  assign RamReadEnable = issue;
  assign RamReadAddr   = addr;

  assign addr_nxt = (addr == ADDR_MAX)
                  ? '0
                  : addr + ADDR_W'(1);

  assign OutValid = (count != '0);
  assign OutData  = OutValid
                  ? fifo_data[rd_ptr]
                  : 8'h00;
  assign OutLast  = OutValid
                  ? fifo_last[rd_ptr]
                  : 1'b0;

  assign push = inflight;
  assign pop  = OutValid && OutReady;

  always_ff @(posedge Clk) begin
    if (Rst || Abort) begin
      state         <= S_IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue
                    && (remaining == REM_ONE);

      if (issue) begin
        addr      <= addr_nxt;
        remaining <= remaining - REM_ONE;
      end

      if (push) begin
        fifo_data[wr_ptr] <= RamReadData;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr <= (wr_ptr == PTR_MAX)
                ? '0
                : wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX)
                ? '0
                : rd_ptr + PW'(1);
      end

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      unique case (1'b1)
        (state == S_RUN): begin
          if (pop && OutLast)
            state <= S_FIN;
        end
        (state == S_IDLE),
        (state == S_FIN): begin
          if (Start) begin
            addr      <= StartAddr;
            remaining <= Length;
            state     <= (Length == '0)
                       ? S_FIN
                       : S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
